// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the memory-access stage and data memory
//
// Ports (signals):
//   dmem_req_o    master->slave  bus request, held for the whole access
//   dmem_we_o     master->slave  1 = write
//   dmem_addr_o   master->slave  word-aligned byte address
//   dmem_wstrb_o  master->slave  byte-lane write strobes
//   dmem_wdata_o  master->slave  lane-replicated store data
//   dmem_ack_i    slave->master  access complete, dmem_rdata_i valid this cycle
//   dmem_rdata_i  slave->master  read word

interface mem_access_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [3:0]      dmem_wstrb_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_ack_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wstrb_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wstrb_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory-access stage: one req/ack bus access per load/store
//
// Ports:
//   clk_i, rst_n         clock, asynchronous active-low reset
//   E_mem_read_i         held op is a load
//   E_mem_write_i        held op is a store
//   E_funct3_i           access size/sign (RISC-V encoding)
//   E_addr_i             byte address
//   E_wdata_i            store data
//   M_flush_i            current op is squashed
//   dmem                 data-memory bus (master side)
//   M_valM_o             registered load result
//   M_stall_o            freeze memory register and upstream
//   M_misalign_o         misaligned access detected, no bus traffic
//   M_bus_err_o          access timed out (one cycle, in DONE)

module mem_access_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 E_mem_read_i,
    input  logic                 E_mem_write_i,
    input  logic [2:0]           E_funct3_i,
    input  logic [XLEN-1:0]      E_addr_i,
    input  logic [XLEN-1:0]      E_wdata_i,
    input  logic                 M_flush_i,
    mem_access_stage_if.master   dmem,
    output logic [XLEN-1:0]      M_valM_o,
    output logic                 M_stall_o,
    output logic                 M_misalign_o,
    output logic                 M_bus_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state_q;
    logic [7:0] cnt_q;

    // Attributes of the access in flight, captured at launch so load
    // extraction does not depend on the execute register afterwards.
    logic       is_read_q;
    logic       is_byte_q;
    logic       is_half_q;
    logic       is_unsigned_q;
    logic [1:0] off_q;
    logic       flushed_q;

    logic       is_byte;
    logic       is_half;
    logic       misaligned;
    logic       mem_op;
    logic       op;
    logic       launch;
    logic       flushed_now;
    logic [3:0]      wstrb_n;
    logic [XLEN-1:0] wdata_n;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext;

    // Store funct3 100/101 are undefined and fall back to word size, while
    // for loads they are the unsigned byte/half variants.
    assign is_byte = (E_funct3_i == 3'b000) | (E_mem_read_i & (E_funct3_i == 3'b100));
    assign is_half = (E_funct3_i == 3'b001) | (E_mem_read_i & (E_funct3_i == 3'b101));

    assign misaligned = (is_half & E_addr_i[0]) |
                        (~is_byte & ~is_half & (E_addr_i[1:0] != 2'b00));

    assign mem_op       = E_mem_read_i | E_mem_write_i;
    assign op           = mem_op & ~misaligned;
    assign launch       = (state_q == ST_IDLE) & op & ~M_flush_i;
    assign M_misalign_o = mem_op & misaligned;
    assign M_stall_o    = launch | (state_q == ST_WAIT);

    // A flush seen in any WAIT cycle, including the completing one,
    // squashes the result and any error report.
    assign flushed_now = flushed_q | M_flush_i;

    always_comb begin
        wstrb_n = 4'b1111;
        wdata_n = E_wdata_i;
        if (is_byte) begin
            wstrb_n = 4'b0001 << E_addr_i[1:0];
            wdata_n = {4{E_wdata_i[7:0]}};
        end else if (is_half) begin
            wstrb_n = E_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{E_wdata_i[15:0]}};
        end
    end

    assign lane_b = dmem.dmem_rdata_i[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];

    always_comb begin
        load_ext = dmem.dmem_rdata_i;
        if (is_byte_q) begin
            load_ext = is_unsigned_q ? {{(XLEN-8){1'b0}}, lane_b}
                                     : {{(XLEN-8){lane_b[7]}}, lane_b};
        end else if (is_half_q) begin
            load_ext = is_unsigned_q ? {{(XLEN-16){1'b0}}, lane_h}
                                     : {{(XLEN-16){lane_h[15]}}, lane_h};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= 8'd0;
            is_read_q         <= 1'b0;
            is_byte_q         <= 1'b0;
            is_half_q         <= 1'b0;
            is_unsigned_q     <= 1'b0;
            off_q             <= 2'b00;
            flushed_q         <= 1'b0;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_wstrb_o <= 4'b0000;
            dmem.dmem_wdata_o <= '0;
            M_valM_o          <= '0;
            M_bus_err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q           <= ST_WAIT;
                        cnt_q             <= 8'd0;
                        is_read_q         <= E_mem_read_i;
                        is_byte_q         <= is_byte;
                        is_half_q         <= is_half;
                        is_unsigned_q     <= E_funct3_i[2];
                        off_q             <= E_addr_i[1:0];
                        flushed_q         <= 1'b0;
                        dmem.dmem_req_o   <= 1'b1;
                        dmem.dmem_we_o    <= E_mem_write_i;
                        dmem.dmem_addr_o  <= {E_addr_i[XLEN-1:2], 2'b00};
                        dmem.dmem_wstrb_o <= E_mem_write_i ? wstrb_n : 4'b0000;
                        dmem.dmem_wdata_o <= wdata_n;
                    end
                end
                ST_WAIT: begin
                    flushed_q <= flushed_now;
                    if (dmem.dmem_ack_i) begin
                        state_q         <= ST_DONE;
                        dmem.dmem_req_o <= 1'b0;
                        M_valM_o        <= (is_read_q & ~flushed_now) ? load_ext : '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q         <= ST_DONE;
                        dmem.dmem_req_o <= 1'b0;
                        M_valM_o        <= '0;
                        M_bus_err_o     <= ~flushed_now;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    M_bus_err_o <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage

module tb_mem_access_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        E_mem_read_i, E_mem_write_i, M_flush_i;
    logic [2:0]  E_funct3_i;
    logic [31:0] E_addr_i, E_wdata_i;
    logic [31:0] M_valM_o;
    logic        M_stall_o, M_misalign_o, M_bus_err_o;

    mem_access_stage_if #(.XLEN(32)) bus ();

    mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .E_mem_read_i  (E_mem_read_i),
        .E_mem_write_i (E_mem_write_i),
        .E_funct3_i    (E_funct3_i),
        .E_addr_i      (E_addr_i),
        .E_wdata_i     (E_wdata_i),
        .M_flush_i     (M_flush_i),
        .dmem          (bus),
        .M_valM_o      (M_valM_o),
        .M_stall_o     (M_stall_o),
        .M_misalign_o  (M_misalign_o),
        .M_bus_err_o   (M_bus_err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit          chk_en = 1'b0;
    bit          exp_req, exp_stall, exp_misalign, exp_err, exp_we;
    logic [31:0] exp_val, exp_addr, exp_wdata, last_val;
    logic [3:0]  exp_wstrb;
    logic [3:0]  seen_wstrb;
    logic [31:0] seen_wdata, seen_addr;
    bit          seen_we;
    int          req_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input bit rd, input logic [2:0] f3);
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        if (rd && f3 == 3'd4) return 1;
        if (rd && f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz = op_size(1'b1, f3);
        logic [31:0] v = w >> ((a % 4) * 8);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] strobe(input logic [2:0] f3, input logic [31:0] a);
        int sz = op_size(1'b0, f3);
        if (sz == 1) return 4'(1 << (a % 4));
        if (sz == 2) return (a % 4 == 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        int sz = op_size(1'b0, f3);
        if (sz == 1) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(M_stall_o), 32'(exp_stall));
            check("req", 32'(bus.dmem_req_o), 32'(exp_req));
            check("misalign", 32'(M_misalign_o), 32'(exp_misalign));
            check("bus_err", 32'(M_bus_err_o), 32'(exp_err));
            check("valM", M_valM_o, exp_val);
            if (exp_req) begin
                check("addr", bus.dmem_addr_o, exp_addr);
                check("we", 32'(bus.dmem_we_o), 32'(exp_we));
                if (exp_we) begin
                    check("wstrb", 32'(bus.dmem_wstrb_o), 32'(exp_wstrb));
                    check("wdata", bus.dmem_wdata_o, exp_wdata);
                end
            end
        end
    end

    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdw, input int k,
                         input bit fl_wait, input bit fl_idle);
        bit mis, launch, timed;
        @(posedge clk); #1;
        E_mem_read_i  = rd;
        E_mem_write_i = wr;
        E_funct3_i    = f3;
        E_addr_i      = a;
        E_wdata_i     = wd;
        M_flush_i     = fl_idle;
        bus.dmem_ack_i   = 1'($urandom_range(0, 1));
        bus.dmem_rdata_i = $urandom;
        mis    = (rd || wr) && (a % op_size(rd, f3) != 0);
        launch = (rd || wr) && !mis && !fl_idle;
        exp_misalign = mis;
        exp_req      = 1'b0;
        exp_err      = 1'b0;
        exp_stall    = launch;
        exp_val      = last_val;
        req_cycles   = 0;
        if (!launch) return;
        exp_addr  = a & ~32'd3;
        exp_we    = wr;
        exp_wstrb = strobe(f3, a);
        exp_wdata = store_data(f3, wd);
        timed = 1'b1;
        for (int w = 0; w < T; w++) begin
            @(posedge clk); #1;
            exp_req      = 1'b1;
            exp_stall    = 1'b1;
            exp_misalign = 1'b0;
            M_flush_i    = fl_wait;
            bus.dmem_ack_i   = (w == k);
            bus.dmem_rdata_i = (w == k) ? rdw : $urandom;
            #1;
            if (bus.dmem_req_o) req_cycles++;
            if (w == 0) begin
                seen_wstrb = bus.dmem_wstrb_o;
                seen_wdata = bus.dmem_wdata_o;
                seen_addr  = bus.dmem_addr_o;
                seen_we    = bus.dmem_we_o;
            end
            if (w == k) begin
                timed = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'($urandom_range(0, 1));
        M_flush_i      = 1'b0;
        last_val  = (rd && !timed && !fl_wait) ? load_val(f3, a, rdw) : 32'd0;
        exp_val   = last_val;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_err   = timed && !fl_wait;
    endtask

    initial begin
        rst_n = 1'b0;
        E_mem_read_i = 1'b0; E_mem_write_i = 1'b0; M_flush_i = 1'b0;
        E_funct3_i = 3'd0; E_addr_i = 32'd0; E_wdata_i = 32'd0;
        bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'd0;
        last_val = 32'd0;
        exp_req = 0; exp_stall = 0; exp_misalign = 0; exp_err = 0; exp_we = 0;
        exp_val = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.dmem_req_o), 32'd0);
        check("rst_we", 32'(bus.dmem_we_o), 32'd0);
        check("rst_addr", bus.dmem_addr_o, 32'd0);
        check("rst_wstrb", 32'(bus.dmem_wstrb_o), 32'd0);
        check("rst_wdata", bus.dmem_wdata_o, 32'd0);
        check("rst_valM", M_valM_o, 32'd0);
        check("rst_err", 32'(M_bus_err_o), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 0);
        #2 check("lw_val", M_valM_o, 32'hDEADBEEF);
        check("lw_req_cycles", 32'(req_cycles), 32'd1);
        do_op(1, 0, 3'b000, 32'h103, 32'd0, 32'h80123456, 0, 0, 0);
        #2 check("lb_val", M_valM_o, 32'hFFFFFF80);
        do_op(1, 0, 3'b100, 32'h103, 32'd0, 32'h80123456, 1, 0, 0);
        #2 check("lbu_val", M_valM_o, 32'h00000080);
        do_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'd0, 3, 0, 0);
        #2 check("sh_valM", M_valM_o, 32'd0);
        check("sh_wstrb", 32'(seen_wstrb), 32'hC);
        check("sh_wdata", seen_wdata, 32'hABCDABCD);
        check("sh_addr", seen_addr, 32'h200);
        check("sh_we", 32'(seen_we), 32'd1);
        check("sh_req_cycles", 32'(req_cycles), 32'd4);
        do_op(1, 0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0, 0);
        #2 check("mis_flag", 32'(M_misalign_o), 32'd1);
        check("mis_stall", 32'(M_stall_o), 32'd0);
        do_op(1, 0, 3'b010, 32'h300, 32'd0, 32'd0, 9, 0, 0);
        #2 check("to_err", 32'(M_bus_err_o), 32'd1);
        check("to_req_cycles", 32'(req_cycles), 32'(T));
        check("to_valM", M_valM_o, 32'd0);
        do_op(1, 0, 3'b010, 32'h300, 32'd0, 32'd0, 9, 1, 0);
        #2 check("to_flush_err", 32'(M_bus_err_o), 32'd0);

        for (int i = 0; i < 250; i++) begin
            int sel = int'($urandom_range(0, 7));
            do_op(sel >= 1 && sel <= 4, sel >= 5, 3'($urandom), $urandom & 32'hFFFF, $urandom,
                  $urandom, int'($urandom_range(0, T + 1)), ($urandom % 8) == 0, ($urandom % 10) == 0);
        end

        do_op(1, 0, 3'b010, 32'h100, 32'd0, 32'hCAFEF00D, 0, 0, 0);
        @(posedge clk); #1;
        E_mem_read_i = 1'b1; E_mem_write_i = 1'b0; E_funct3_i = 3'b010;
        E_addr_i = 32'h104; M_flush_i = 1'b0; bus.dmem_ack_i = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_misalign = 1'b0; exp_err = 1'b0;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_addr = 32'h104; exp_we = 1'b0;
        #2 check("pre_rst_req", 32'(bus.dmem_req_o), 32'd1);
        check("pre_rst_valM", M_valM_o, 32'hCAFEF00D);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_req", 32'(bus.dmem_req_o), 32'd0);
        check("arst_addr", bus.dmem_addr_o, 32'd0);
        check("arst_valM", M_valM_o, 32'd0);
        check("arst_err", 32'(M_bus_err_o), 32'd0);
        check("arst_we", 32'(bus.dmem_we_o), 32'd0);
        E_mem_read_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_val = 32'd0;
        exp_val = 32'd0; exp_req = 1'b0; exp_stall = 1'b0; exp_err = 1'b0; exp_misalign = 1'b0;
        chk_en = 1'b1;
        do_op(1, 0, 3'b010, 32'h40, 32'd0, 32'h12345678, 1, 0, 0);
        #2 check("post_rst_lw", M_valM_o, 32'h12345678);

        @(posedge clk); #1;
        E_mem_read_i = 1'b0; E_mem_write_i = 1'b0;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
